btn_debounce_mc: RTL and testbench
==================================

# btn_debounce_mc

Parametrised multi-channel push-button conditioner: synchronises `NUM_CH` raw asynchronous button inputs, debounces each one independently with a per-channel state machine, and produces a clean level plus single-cycle press, release and long-press event pulses per channel. It sits directly behind the board button pins and feeds the control FSMs, replacing single-button, press-only debouncing.

## Interface
- `NUM_CH`, 4: number of independent button channels (≥1).
- `STABLE_CYCLES`, 2500: consecutive synchronised samples required to accept a level change (≥1).
- `LONG_CYCLES`, 1000000: cycles the debounced level must stay high, counted from its rising edge, to emit a long-press pulse (≥1).
- `clk` in 1: system clock. One clock; all logic rises on `posedge clk`.
- `rst` in 1: synchronous, active-high reset.
- `btn_in` in NUM_CH: raw, asynchronous, active-high buttons.
- `btn_level` out NUM_CH: debounced level.
- `btn_press` out NUM_CH: 1-cycle pulse on accepted 0→1.
- `btn_release` out NUM_CH: 1-cycle pulse on accepted 1→0.
- `btn_long` out NUM_CH: 1-cycle pulse, at most once per press.

## Operation
- Per channel: 2-flop synchroniser (`sync1`, `sync2`; `s` = `sync2`), debounce FSM with counter `cnt`, long-press counter `lcnt`, and a `long_done` flag.
- FSM states: `REL` (stable low), `ARM_P` (qualifying high), `HELD` (stable high), `ARM_R` (qualifying low).
- `REL`: `s`=1 → `ARM_P`, `cnt`=1; if `STABLE_CYCLES`=1, go directly to `HELD` instead.
- `ARM_P`: `s`=0 → `REL`, `cnt`=0 (bounce restarts qualification). `s`=1 and `cnt`=`STABLE_CYCLES`-1 → `HELD`, `btn_level`←1, `btn_press` pulses. Otherwise `cnt`++.
- `HELD`: `s`=0 → `ARM_R`, `cnt`=1; if `STABLE_CYCLES`=1, go directly to `REL`.
- `ARM_R`: mirrors `ARM_P` with polarity inverted. On acceptance go to `REL`, `btn_level`←0, `btn_release` pulses. A bounce back to `s`=1 returns to `HELD`.
- Long press: `lcnt` clears on entry to `HELD` from `ARM_P`/`REL`. It increments every cycle while `btn_level`=1, including `ARM_R`. It saturates at `LONG_CYCLES` and never wraps.
- When `lcnt` reaches `LONG_CYCLES` and `long_done`=0, `btn_long` pulses and `long_done`←1. `long_done` clears on release acceptance.
- A release accepted before `LONG_CYCLES` produces no `btn_long`.
- Channels are fully independent. Simultaneous events on different channels each pulse in the same cycle.
- Widths: `cnt` is `$clog2(STABLE_CYCLES+1)` bits; `lcnt` is `$clog2(LONG_CYCLES+1)` bits.

## Timing
- Reset (`rst`=1 at an edge) forces all sync flops, counters, `long_done` to 0 and FSM to `REL`. All outputs become 0 after that edge.
- Reset mid-qualification or mid-press discards state and emits no release pulse.
- Latency: number edges from the edge that first captures `btn_in`=1 into `sync1` (edge 1). `btn_level` and `btn_press` update at edge `STABLE_CYCLES`+2, provided `btn_in` stays high. Release uses the same rule.
- `btn_long` asserts at edge t0+`LONG_CYCLES`, where t0 is the edge at which `btn_level` rose.
- All pulses are exactly one cycle wide and registered; there are no combinational paths from inputs to outputs.
- `btn_press` and `btn_release` never coincide on one channel. `btn_long` can coincide with neither.

## Structure
- Shared package `btn_pkg` holds the FSM state enum (`REL`, `ARM_P`, `HELD`, `ARM_R`) and a `CNT_W` helper function.
- Sub-module `btn_debounce_ch` implements one channel (synchroniser, FSM, both counters) with parameters `STABLE_CYCLES` and `LONG_CYCLES`.
- The top level is a generate loop of `NUM_CH` instances.

## Test plan
All scenarios use `NUM_CH`=2, `STABLE_CYCLES`=4, `LONG_CYCLES`=20.
- Reset: hold `rst` 3 cycles with `btn_in`=2'b11 → all outputs 0 during reset and at the first edge after.
- Clean press on ch0, raw high captured at edge 1 → `btn_level[0]`=1 and `btn_press[0]` pulse at edge 6. Ch1 outputs stay 0.
- Bounce: ch0 pattern 1,1,1,0,1,1,1,1 (synchronised) → no press after the first three 1s. Press occurs on the 4th consecutive 1 of the final run.
- Short press held 10 cycles after acceptance, then clean release → `btn_release[0]` pulse 6 edges after raw low is captured. No `btn_long`.
- Long press held 50 cycles → exactly one `btn_long[0]` at t0+20 and no repeat. The release pulse then follows normally.
- Simultaneous: both channels pressed on the same edge → `btn_press`=2'b11 in one cycle. Assert `rst` during ch1's `ARM_R` → no `btn_release[1]`.

Source files
------------

// File: rtl/btn_pkg.sv
// Shared types and helpers for the multi-channel button conditioner.
package btn_pkg;

  typedef enum logic [1:0] {
    REL   = 2'd0,
    ARM_P = 2'd1,
    HELD  = 2'd2,
    ARM_R = 2'd3
  } btn_state_e;

  // Width of a counter that must hold values 0..n inclusive.
  function automatic int CNT_W(input int n);
    return (n < 1) ? 1 : $clog2(n + 1);
  endfunction

endpackage

// File: rtl/btn_debounce_ch.sv
// One button channel: 2-flop synchroniser, debounce FSM, long-press counter.
// Press/release after STABLE_CYCLES+2 edges; long pulse LONG_CYCLES edges after the level rises.
module btn_debounce_ch
  import btn_pkg::*;
#(
  parameter int STABLE_CYCLES = 2500,
  parameter int LONG_CYCLES   = 1000000
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_raw,
  output logic level,
  output logic press_pls,
  output logic release_pls,
  output logic long_pls
);

  localparam int SW = CNT_W(STABLE_CYCLES);
  localparam int LW = CNT_W(LONG_CYCLES);
  localparam logic [SW-1:0] CNT_LAST = SW'(STABLE_CYCLES - 1);
  localparam logic [LW-1:0] LCNT_MAX = LW'(LONG_CYCLES);

  logic          sync1, sync2;
  btn_state_e    state, state_nxt;
  logic [SW-1:0] cnt, cnt_nxt;
  logic [LW-1:0] lcnt, lcnt_nxt;
  logic          long_done, long_done_nxt;
  logic          press_nxt, release_nxt, long_nxt;

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1       <= 1'b0;
      sync2       <= 1'b0;
      state       <= REL;
      cnt         <= '0;
      lcnt        <= '0;
      long_done   <= 1'b0;
      press_pls   <= 1'b0;
      release_pls <= 1'b0;
      long_pls    <= 1'b0;
    end else begin
      sync1       <= btn_raw;
      sync2       <= sync1;
      state       <= state_nxt;
      cnt         <= cnt_nxt;
      lcnt        <= lcnt_nxt;
      long_done   <= long_done_nxt;
      press_pls   <= press_nxt;
      release_pls <= release_nxt;
      long_pls    <= long_nxt;
    end
  end

  always_comb begin
    state_nxt     = state;
    cnt_nxt       = cnt;
    press_nxt     = 1'b0;
    release_nxt   = 1'b0;
    lcnt_nxt      = lcnt;
    long_done_nxt = long_done;
    long_nxt      = 1'b0;

    case (state)
      REL: begin
        if (sync2) begin
          if (STABLE_CYCLES == 1) begin
            state_nxt = HELD;
            press_nxt = 1'b1;
            cnt_nxt   = '0;
          end else begin
            state_nxt = ARM_P;
            cnt_nxt   = SW'(1);
          end
        end
      end
      ARM_P: begin
        if (!sync2) begin
          state_nxt = REL;
          cnt_nxt   = '0;
        end else if (cnt == CNT_LAST) begin
          state_nxt = HELD;
          press_nxt = 1'b1;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt = cnt + SW'(1);
        end
      end
      HELD: begin
        if (!sync2) begin
          if (STABLE_CYCLES == 1) begin
            state_nxt   = REL;
            release_nxt = 1'b1;
            cnt_nxt     = '0;
          end else begin
            state_nxt = ARM_R;
            cnt_nxt   = SW'(1);
          end
        end
      end
      ARM_R: begin
        if (sync2) begin
          state_nxt = HELD;
          cnt_nxt   = '0;
        end else if (cnt == CNT_LAST) begin
          state_nxt   = REL;
          release_nxt = 1'b1;
          cnt_nxt     = '0;
        end else begin
          cnt_nxt = cnt + SW'(1);
        end
      end
      default: begin
        state_nxt = REL;
        cnt_nxt   = '0;
      end
    endcase

    // Long-press count runs while the debounced level is high and saturates.
    if (press_nxt) begin
      lcnt_nxt = '0;
    end else if (level && (lcnt != LCNT_MAX)) begin
      lcnt_nxt = lcnt + LW'(1);
    end

    // Suppressed on the release edge so long never coincides with release.
    if (release_nxt) begin
      long_done_nxt = 1'b0;
    end else if (level && !long_done && (lcnt_nxt == LCNT_MAX)) begin
      long_nxt      = 1'b1;
      long_done_nxt = 1'b1;
    end
  end

  always_comb begin
    level = (state == HELD) || (state == ARM_R);
  end

endmodule

// File: rtl/btn_debounce_mc.sv
// NUM_CH independent debounced buttons with level, press, release and long-press pulses.
module btn_debounce_mc
  import btn_pkg::*;
#(
  parameter int NUM_CH        = 4,
  parameter int STABLE_CYCLES = 2500,
  parameter int LONG_CYCLES   = 1000000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NUM_CH-1:0] btn_in,
  output logic [NUM_CH-1:0] btn_level,
  output logic [NUM_CH-1:0] btn_press,
  output logic [NUM_CH-1:0] btn_release,
  output logic [NUM_CH-1:0] btn_long
);

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    btn_debounce_ch #(
      .STABLE_CYCLES(STABLE_CYCLES),
      .LONG_CYCLES  (LONG_CYCLES)
    ) u_ch (
      .clk        (clk),
      .rst        (rst),
      .btn_raw    (btn_in[g]),
      .level      (btn_level[g]),
      .press_pls  (btn_press[g]),
      .release_pls(btn_release[g]),
      .long_pls   (btn_long[g])
    );
  end

endmodule

// File: tb/tb_btn_debounce_mc.sv
// Directed, table-driven check of btn_debounce_mc with 2 channels, STABLE=4, LONG=20.
module tb_btn_debounce_mc;

  logic       clk = 1'b0;
  logic       rst;
  logic [1:0] btn_in;
  logic [1:0] btn_level, btn_press, btn_release, btn_long;

  int n_chk  = 0;
  int n_fail = 0;

  btn_debounce_mc #(
    .NUM_CH       (2),
    .STABLE_CYCLES(4),
    .LONG_CYCLES  (20)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .btn_in     (btn_in),
    .btn_level  (btn_level),
    .btn_press  (btn_press),
    .btn_release(btn_release),
    .btn_long   (btn_long)
  );

  always #5 clk = ~clk;

  // One row per clock edge: input applied before the edge, outputs expected after it.
  typedef struct packed {
    logic [1:0] in;
    logic [1:0] lvl;
    logic [1:0] pr;
    logic [1:0] rl;
    logic [1:0] lg;
  } vec_t;

  vec_t tbl[$];

  function automatic void seg(input int n, input logic [1:0] in, input logic [1:0] lvl,
                              input logic [1:0] pr, input logic [1:0] rl, input logic [1:0] lg);
    vec_t v;
    v.in  = in;
    v.lvl = lvl;
    v.pr  = pr;
    v.rl  = rl;
    v.lg  = lg;
    for (int k = 0; k < n; k++) tbl.push_back(v);
  endfunction

  task automatic check(input string name, input int idx, input logic [7:0] exp);
    logic [7:0] act;
    act = {btn_level, btn_press, btn_release, btn_long};
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s[%0d]: lvl/pr/rl/lg got %b expected %b", name, idx, act, exp);
    end
  endtask

  task automatic step(input logic r, input logic [1:0] in);
    rst    = r;
    btn_in = in;
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst    = 1'b1;
    btn_in = 2'b11;
    #2;

    // Reset held with buttons pressed: outputs stay zero.
    for (int i = 0; i < 3; i++) begin
      step(1'b1, 2'b11);
      check("reset", i, 8'h00);
    end
    // First edge after reset, then a one-cycle glitch drains through the synchroniser.
    step(1'b0, 2'b11);
    check("post_reset", 0, 8'h00);
    for (int i = 0; i < 5; i++) begin
      step(1'b0, 2'b00);
      check("glitch", i, 8'h00);
    end

    // Clean press on ch0, short hold, clean release (no long).
    seg(5,  2'b01, 2'b00, 2'b00, 2'b00, 2'b00);
    seg(1,  2'b01, 2'b01, 2'b01, 2'b00, 2'b00);
    seg(10, 2'b01, 2'b01, 2'b00, 2'b00, 2'b00);
    seg(5,  2'b00, 2'b01, 2'b00, 2'b00, 2'b00);
    seg(1,  2'b00, 2'b00, 2'b00, 2'b01, 2'b00);
    seg(3,  2'b00, 2'b00, 2'b00, 2'b00, 2'b00);
    // Bounce 1,1,1,0 then a run of 1s: press on the 4th 1 of the run.
    seg(3,  2'b01, 2'b00, 2'b00, 2'b00, 2'b00);
    seg(1,  2'b00, 2'b00, 2'b00, 2'b00, 2'b00);
    seg(5,  2'b01, 2'b00, 2'b00, 2'b00, 2'b00);
    seg(1,  2'b01, 2'b01, 2'b01, 2'b00, 2'b00);
    // Long press: pulse 20 edges after the level rose, then no repeat.
    seg(19, 2'b01, 2'b01, 2'b00, 2'b00, 2'b00);
    seg(1,  2'b01, 2'b01, 2'b00, 2'b00, 2'b01);
    seg(30, 2'b01, 2'b01, 2'b00, 2'b00, 2'b00);
    // Release with a bounce back high during qualification.
    seg(3,  2'b00, 2'b01, 2'b00, 2'b00, 2'b00);
    seg(1,  2'b01, 2'b01, 2'b00, 2'b00, 2'b00);
    seg(5,  2'b00, 2'b01, 2'b00, 2'b00, 2'b00);
    seg(1,  2'b00, 2'b00, 2'b00, 2'b01, 2'b00);
    seg(3,  2'b00, 2'b00, 2'b00, 2'b00, 2'b00);
    // Both channels pressed together.
    seg(5,  2'b11, 2'b00, 2'b00, 2'b00, 2'b00);
    seg(1,  2'b11, 2'b11, 2'b11, 2'b00, 2'b00);
    seg(2,  2'b11, 2'b11, 2'b00, 2'b00, 2'b00);

    foreach (tbl[i]) begin
      step(1'b0, tbl[i].in);
      check("vec", i, {tbl[i].lvl, tbl[i].pr, tbl[i].rl, tbl[i].lg});
    end

    // Release ch1 only; reset lands while ch1 is qualifying the release.
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 2'b01);
      check("arm_r", i, 8'b11_00_00_00);
    end
    step(1'b1, 2'b01);
    check("rst_mid", 0, 8'h00);
    for (int i = 0; i < 8; i++) begin
      step(1'b0, 2'b00);
      check("after_rst", i, 8'h00);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
